// File: rtl/fetch_pkg.sv
// fetch_pkg: jump-control encodings and counter-width helper for the fetch stage
package fetch_pkg;
    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JUMP = 2'b01;
    localparam logic [1:0] J_JR   = 2'b10;
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, push, pop and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    assign rdata = mem[rp];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: instruction fetch with prefetch queue, credit-limited requests and redirect flush
module fetch_prefetch
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_con_b,
    input  logic [1:0]        i_con_j,
    input  logic [ADDR_W-1:0] i_addr_b,
    input  logic [ADDR_W-1:0] i_addr_j,
    input  logic [ADDR_W-1:0] i_addr_jr,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    input  logic              i_req_ready,
    input  logic              i_rsp_valid,
    input  logic [DATA_W-1:0] i_rsp_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data_instr,
    output logic [ADDR_W-1:0] o_addr_pc4,
    input  logic              i_ready
);
    localparam int CW = cnt_w(DEPTH);
    logic [ADDR_W-1:0] pc, target, tag;
    logic [CW-1:0]     count, outst, drop;
    logic [CW:0]       credit;
    logic              run, redirect, acc, pop, q_push;
    assign redirect    = (i_con_j == J_JR) || (i_con_j == J_JUMP) || i_con_b;
    assign target      = (i_con_j == J_JR) ? i_addr_jr : (i_con_j == J_JUMP) ? i_addr_j : i_addr_b;
    assign credit      = {1'b0, count} + {1'b0, outst};
    assign o_req_valid = run & ~redirect & (credit < (CW+1)'(DEPTH));
    assign o_req_addr  = pc;
    assign acc         = o_req_valid & i_req_ready;
    assign o_valid     = count != '0;
    assign pop         = o_valid & i_ready;
    assign q_push      = i_rsp_valid & (drop == '0) & ~redirect;
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            pc   <= RESET_PC;
            run  <= 1'b0;
            drop <= '0;
        end else begin
            run  <= 1'b1;
            pc   <= redirect ? target : acc ? pc + ADDR_W'(4) : pc;
            drop <= redirect ? outst - CW'(i_rsp_valid) : drop - CW'(i_rsp_valid && drop != '0);
        end
    end
    fetch_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(DEPTH)) u_queue (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .flush (redirect),
        .push  (q_push),
        .pop   (pop),
        .wdata ({tag, i_rsp_data}),
        .rdata ({o_addr_pc4, o_data_instr}),
        .count (count)
    );
    fetch_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tags (
        .clk   (i_clk),
        .rst_n (i_nrst),
        .flush (1'b0),
        .push  (acc),
        .pop   (i_rsp_valid),
        .wdata (pc + ADDR_W'(4)),
        .rdata (tag),
        .count (outst)
    );
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed scoreboard bench for fetch_prefetch with an in-order memory model
module tb_fetch_prefetch;
    logic        i_clk = 1'b0;
    logic        i_nrst = 1'b1;
    logic        i_con_b = 1'b0;
    logic [1:0]  i_con_j = 2'b00;
    logic [31:0] i_addr_b = '0, i_addr_j = '0, i_addr_jr = '0;
    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        i_req_ready = 1'b1;
    logic        i_rsp_valid = 1'b0;
    logic [31:0] i_rsp_data = '0;
    logic        o_valid;
    logic [31:0] o_data_instr, o_addr_pc4;
    logic        i_ready = 1'b0;

    typedef struct {
        logic [31:0] a;
        int          due;
    } req_t;

    req_t        pend[$];
    logic [31:0] exp_req[$];
    logic [31:0] exp_dec[$];
    int          cyc = 0;
    int          lat = 1;
    int          nacc = 0;
    int          nvec = 0;
    int          nfail = 0;

    fetch_prefetch dut (
        .i_clk        (i_clk),
        .i_nrst       (i_nrst),
        .i_con_b      (i_con_b),
        .i_con_j      (i_con_j),
        .i_addr_b     (i_addr_b),
        .i_addr_j     (i_addr_j),
        .i_addr_jr    (i_addr_jr),
        .o_req_valid  (o_req_valid),
        .o_req_addr   (o_req_addr),
        .i_req_ready  (i_req_ready),
        .i_rsp_valid  (i_rsp_valid),
        .i_rsp_data   (i_rsp_data),
        .o_valid      (o_valid),
        .o_data_instr (o_data_instr),
        .o_addr_pc4   (o_addr_pc4),
        .i_ready      (i_ready)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        @(negedge i_clk);
        i_nrst  = 1'b0;
        i_con_b = 1'b0;
        i_con_j = 2'b00;
        exp_dec.delete();
        exp_req.delete();
        repeat (2) @(negedge i_clk);
        i_nrst = 1'b1;
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_dec.size() != 0 || exp_req.size() != 0) && n < max) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain", 64'(exp_dec.size() + exp_req.size()), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, 64'(o_req_valid), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_instr"}, 64'(o_data_instr), 64'd0);
        chk({tag, "_pc4"}, 64'(o_addr_pc4), 64'd0);
        chk({tag, "_req_addr"}, 64'(o_req_addr), 64'd0);
    endtask

    // In-order memory: responds lat cycles after acceptance, cleared by reset
    initial forever begin
        @(negedge i_clk);
        if (i_nrst && pend.size() != 0 && pend[0].due <= cyc) begin
            i_rsp_valid = 1'b1;
            i_rsp_data  = instr_of(pend[0].a);
        end else begin
            i_rsp_valid = 1'b0;
        end
        #4;
        if (!i_nrst) begin
            pend.delete();
            nacc        = 0;
            i_rsp_valid = 1'b0;
        end else begin
            if (i_rsp_valid) void'(pend.pop_front());
            if (o_req_valid && i_req_ready) begin
                pend.push_back('{o_req_addr, cyc + lat});
                nacc++;
            end
        end
    end

    initial forever begin
        logic [31:0] p;
        @(negedge i_clk);
        #4;
        if (i_nrst) begin
            if (o_req_valid && i_req_ready && exp_req.size() != 0)
                chk("req_addr", 64'(o_req_addr), 64'(exp_req.pop_front()));
            if (o_valid && i_ready && exp_dec.size() != 0) begin
                p = exp_dec.pop_front();
                chk("dec_pc4", 64'(o_addr_pc4), 64'(p));
                chk("dec_instr", 64'(o_data_instr), 64'(instr_of(p - 32'd4)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #1 i_nrst = 1'b0;
        #2 chk_reset_outputs("rst0");

        lat = 1; i_ready = 1'b1; i_req_ready = 1'b1;
        reset_dut();
        for (int k = 0; k < 16; k++) begin
            exp_req.push_back(32'(4 * k));
            exp_dec.push_back(32'(4 * k + 4));
        end
        repeat (18) @(negedge i_clk);
        chk("t1_left_before_last", 64'(exp_dec.size()), 64'd1);
        @(negedge i_clk);
        chk("t1_stream_done", 64'(exp_dec.size() + exp_req.size()), 64'd0);

        lat = 1; i_ready = 1'b0; i_req_ready = 1'b1;
        reset_dut();
        for (int k = 0; k < 4; k++) exp_req.push_back(32'(4 * k));
        repeat (10) @(negedge i_clk);
        #4;
        chk("t2_nreq", 64'(nacc), 64'd4);
        chk("t2_valid", 64'(o_valid), 64'd1);
        chk("t2_head", 64'(o_addr_pc4), 64'd4);
        chk("t2_req_blocked", 64'(o_req_valid), 64'd0);
        @(negedge i_clk);
        for (int k = 1; k <= 12; k++) exp_dec.push_back(32'(4 * k));
        i_ready = 1'b1;
        wait_drain(40);

        lat = 3; i_ready = 1'b1; i_req_ready = 1'b1;
        reset_dut();
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_req.push_back(32'h100);
        exp_req.push_back(32'h104);
        exp_dec.push_back(32'h104);
        exp_dec.push_back(32'h108);
        repeat (3) @(negedge i_clk);
        i_con_j  = 2'b01;
        i_addr_j = 32'h100;
        #4 chk("t3_no_req_on_redirect", 64'(o_req_valid), 64'd0);
        @(negedge i_clk);
        i_con_j = 2'b00;
        wait_drain(40);

        lat = 1; i_ready = 1'b1; i_req_ready = 1'b1;
        reset_dut();
        foreach (exp_req[i]) exp_req.delete(i);
        exp_req = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h200, 32'h204};
        exp_dec = '{32'h4, 32'h8, 32'hC, 32'h204, 32'h208, 32'h20C};
        repeat (5) @(negedge i_clk);
        i_con_j   = 2'b10;
        i_addr_jr = 32'h200;
        i_con_b   = 1'b1;
        i_addr_b  = 32'h300;
        i_addr_j  = 32'h400;
        @(negedge i_clk);
        i_con_j = 2'b00;
        i_con_b = 1'b0;
        wait_drain(40);

        lat = 1; i_ready = 1'b1; i_req_ready = 1'b0;
        reset_dut();
        exp_req = '{32'h0, 32'h4, 32'h8};
        exp_dec = '{32'h4, 32'h8};
        repeat (5) begin
            @(negedge i_clk);
            #4;
            chk("t5_hold_valid", 64'(o_req_valid), 64'd1);
            chk("t5_hold_addr", 64'(o_req_addr), 64'd0);
        end
        @(negedge i_clk);
        i_req_ready = 1'b1;
        wait_drain(40);

        lat = 3; i_ready = 1'b0; i_req_ready = 1'b1;
        reset_dut();
        repeat (6) @(negedge i_clk);
        #1;
        chk("t6_pre_valid", 64'(o_valid), 64'd1);
        chk("t6_pre_head", 64'(o_addr_pc4), 64'd4);
        chk("t6_pre_credit_full", 64'(o_req_valid), 64'd0);
        #1 i_nrst = 1'b0;
        #1 chk_reset_outputs("t6_async");
        lat = 1; i_ready = 1'b1;
        reset_dut();
        exp_req = '{32'h0, 32'h4};
        exp_dec = '{32'h4, 32'h8};
        wait_drain(40);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
